shim_avst_pkt_mux: RTL and testbench

- N-input, packet-aware Avalon-ST multiplexer for the shim layer. Merges NUM_CH source streams into one sink stream using round-robin arbitration.
- Once a channel is granted, it keeps the grant until its end-of-packet beat is accepted.
- Each output beat carries the source channel number.
- Output is registered through a 2-entry skid buffer, so out_ready never reaches input ready combinationally.
- Sits between kernel-side stream producers and a single host/DMA-side shim stream.

---
 rtl/dc_bsp_pkg.sv | 20 ++
 rtl/shim_avst_skid_buf.sv | 75 +++++++
 rtl/shim_avst_pkt_mux.sv | 211 +++++++++++++++++++++
 tb/tb_shim_avst_pkt_mux.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_bsp_pkg.sv
// ---------------------------------------------------------------------------
// dc_bsp_pkg
// Shared board-support constants and types for the shim layer.
//   SHIM_AVST_DATA_WIDTH : payload width of shim Avalon-ST streams (bits)
//   SHIM_AVST_MUX_NUM_CH : default channel count of shim_avst_pkt_mux
//   shim_avst_mux_state_e: packet-mux arbiter state (IDLE / LOCKED)
// ---------------------------------------------------------------------------
package dc_bsp_pkg;

    localparam int SHIM_AVST_DATA_WIDTH = 64;
    localparam int SHIM_AVST_MUX_NUM_CH = 4;

    // IDLE   : no packet in flight, round-robin search picks the next source
    // LOCKED : a packet is open, only its owner may send until its eop
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } shim_avst_mux_state_e;

endpackage

// File: rtl/shim_avst_skid_buf.sv
// ---------------------------------------------------------------------------
// shim_avst_skid_buf
// Two-entry registered FIFO used as the output stage of the packet mux.
// The head entry drives out_data straight from a register, and the 'space'
// flag is derived from the registered occupancy only, so the downstream
// ready never reaches the upstream ready combinationally.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   push_valid   : write push_data this cycle (ignored when no space)
//   push_data    : W-bit payload to store
//   space        : at least one free entry (count < 2), registered-only
//   out_valid    : head entry is valid (count != 0)
//   out_ready    : sink takes the head entry this cycle
//   out_data     : head entry payload
// ---------------------------------------------------------------------------
module shim_avst_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         space,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic [1:0]   count_q, count_d;
    logic         push;
    logic         pop;

    assign space     = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = ent0_q;
    assign push      = push_valid && space;
    assign pop       = out_ready && out_valid;

    // Pop first (shift entry 1 into the head), then write the new beat into
    // the first free slot of the post-pop occupancy. A simultaneous push and
    // pop therefore keeps count and preserves FIFO order.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (pop) begin
            ent0_d  = ent1_q;
            count_d = count_q - 2'd1;
        end
        if (push) begin
            if (count_d == 2'd0) begin
                ent0_d = push_data;
            end else begin
                ent1_d = push_data;
            end
            count_d = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/shim_avst_pkt_mux.sv
// ---------------------------------------------------------------------------
// shim_avst_pkt_mux
// Packet-aware NUM_CH:1 Avalon-ST multiplexer. Sources are picked
// round-robin; once a multi-beat packet starts, its channel owns the output
// until its eop beat is accepted. Every output beat carries its source
// channel. The output goes through a 2-entry skid buffer.
//
// Optional build macro: SHIM_AVST_PKT_MUX_PROTO_CHECK_EN
//   defined   : proto_err goes high (sticky until reset) when an accepted
//               beat has sop=0 while IDLE or sop=1 while LOCKED; the beat
//               is still forwarded unchanged.
//   undefined : proto_err is tied low, no checking logic.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   in_valid    : [NUM_CH] per-channel valid
//   in_ready    : [NUM_CH] per-channel ready (at most one bit high)
//   in_data     : [NUM_CH*DATA_WIDTH] channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_sop/eop  : [NUM_CH] packet delimiters
//   in_empty    : [NUM_CH*EMPTY_WIDTH] unused bytes on eop beats
//   out_valid/out_ready/out_data/out_sop/out_eop : sink stream
//   out_empty   : unused bytes on eop beats, 0 otherwise
//   out_channel : source channel of the output beat
//   proto_err   : sticky protocol error flag
// ---------------------------------------------------------------------------
module shim_avst_pkt_mux
    import dc_bsp_pkg::*;
#(
    parameter int DATA_WIDTH  = SHIM_AVST_DATA_WIDTH,
    parameter int NUM_CH      = SHIM_AVST_MUX_NUM_CH,
    parameter int EMPTY_WIDTH = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1,
    parameter int CH_WIDTH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             in_valid,
    output logic [NUM_CH-1:0]             in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_CH-1:0]             in_sop,
    input  logic [NUM_CH-1:0]             in_eop,
    input  logic [NUM_CH*EMPTY_WIDTH-1:0] in_empty,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [EMPTY_WIDTH-1:0]        out_empty,
    output logic [CH_WIDTH-1:0]           out_channel,
    output logic                          proto_err
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_WIDTH-1:0] empty;
        logic [CH_WIDTH-1:0]    channel;
    } beat_t;

    // Channel after ch, wrapping NUM_CH-1 -> 0.
    function automatic logic [CH_WIDTH-1:0] next_ch(input logic [CH_WIDTH-1:0] ch);
        if (int'(ch) >= NUM_CH - 1) begin
            return '0;
        end
        return ch + 1'b1;
    endfunction

    // First requesting channel at or after ptr, with wrap-around.
    function automatic logic [CH_WIDTH-1:0] rr_search(
        input logic [NUM_CH-1:0]   req,
        input logic [CH_WIDTH-1:0] ptr
    );
        logic [CH_WIDTH-1:0] sel;
        logic [CH_WIDTH-1:0] idx;
        logic                found;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_WIDTH'((int'(ptr) + i) % NUM_CH);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    logic [NUM_CH-1:0][DATA_WIDTH-1:0]  ch_data;
    logic [NUM_CH-1:0][EMPTY_WIDTH-1:0] ch_empty;

    assign ch_data  = in_data;
    assign ch_empty = in_empty;

    shim_avst_mux_state_e state_q, state_d;
    logic [CH_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CH_WIDTH-1:0]  owner_q, owner_d;

    logic [CH_WIDTH-1:0]  grant;
    logic                 grant_valid;
    logic                 accept;
    logic                 space;
    beat_t                push_beat;
    beat_t                head_beat;
    logic                 buf_valid;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        grant       = '0;
        grant_valid = 1'b0;
        in_ready    = '0;
        push_beat   = '0;

        // While LOCKED only the owner is eligible, even if it is stalling,
        // so packets never interleave on the output.
        if (state_q == LOCKED) begin
            grant       = owner_q;
            grant_valid = in_valid[owner_q];
        end else begin
            grant       = rr_search(in_valid, rr_ptr_q);
            grant_valid = |in_valid;
        end

        accept = grant_valid && space;
        if (accept) begin
            in_ready[grant] = 1'b1;
        end

        push_beat.data    = ch_data[grant];
        push_beat.sop     = in_sop[grant];
        push_beat.eop     = in_eop[grant];
        push_beat.empty   = in_eop[grant] ? ch_empty[grant] : '0;
        push_beat.channel = grant;

        if (accept) begin
            if (state_q == IDLE) begin
                // Single-beat packets never lock; the pointer moves on at once
                // so a different channel can follow on the next cycle.
                if (in_eop[grant]) begin
                    rr_ptr_d = next_ch(grant);
                end else begin
                    state_d = LOCKED;
                    owner_d = grant;
                end
            end else if (in_eop[grant]) begin
                state_d  = IDLE;
                rr_ptr_d = next_ch(owner_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    shim_avst_skid_buf #(
        .W($bits(beat_t))
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push_valid(accept),
        .push_data (push_beat),
        .space     (space),
        .out_valid (buf_valid),
        .out_ready (out_ready),
        .out_data  (head_beat)
    );

    assign out_valid   = buf_valid;
    assign out_data    = head_beat.data;
    assign out_sop     = head_beat.sop;
    assign out_eop     = head_beat.eop;
    assign out_empty   = head_beat.empty;
    assign out_channel = head_beat.channel;

`ifdef SHIM_AVST_PKT_MUX_PROTO_CHECK_EN
    logic proto_err_q, proto_err_d;

    always_comb begin
        proto_err_d = proto_err_q;
        if (accept) begin
            if ((state_q == IDLE && !in_sop[grant]) ||
                (state_q == LOCKED && in_sop[grant])) begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_shim_avst_pkt_mux.sv
module tb_shim_avst_pkt_mux;

    localparam int DW   = 64;
    localparam int NCH  = 4;
    localparam int EW   = 3;
    localparam int CW   = 2;
    localparam int MAXB = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic [NCH-1:0]      in_valid;
    logic [NCH-1:0]      in_ready;
    logic [NCH*DW-1:0]   in_data;
    logic [NCH-1:0]      in_sop;
    logic [NCH-1:0]      in_eop;
    logic [NCH*EW-1:0]   in_empty;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;
    logic                out_sop;
    logic                out_eop;
    logic [EW-1:0]       out_empty;
    logic [CW-1:0]       out_channel;
    logic                proto_err;

    always #5 clk = ~clk;

    shim_avst_pkt_mux #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
        .out_channel(out_channel), .proto_err(proto_err)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        int            ch;
        int            cyc;
    } beat_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 0;

    // Source beat storage per channel
    logic [DW-1:0] s_data  [NCH][MAXB];
    logic          s_sop   [NCH][MAXB];
    logic          s_eop   [NCH][MAXB];
    logic [EW-1:0] s_empty [NCH][MAXB];
    int            s_len   [NCH];
    int            s_idx   [NCH];
    int            pkt_id = 1;

    // Reference model: open-packet owner (-1 = none), rr pointer, output queue
    beat_t m_fifo[$];
    int    m_owner = -1;
    int    m_rr    = 0;
    int    m_acc   = -1;
    bit    m_perr  = 0;

    beat_t log_q[$];
    bit    blk_flag;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int m_grant();
        if (m_owner >= 0) return in_valid[m_owner] ? m_owner : -1;
        for (int i = 0; i < NCH; i++) begin
            if (in_valid[(m_rr + i) % NCH]) return (m_rr + i) % NCH;
        end
        return -1;
    endfunction

    // Model step on every clock edge
    always @(posedge clk) begin
        int    g;
        bit    sp;
        beat_t b;
        cyc++;
        m_acc = -1;
        if (reset) begin
            m_fifo.delete();
            m_owner = -1;
            m_rr    = 0;
            m_perr  = 0;
        end else begin
            g  = m_grant();
            sp = (m_fifo.size() < 2);
            if (out_ready && m_fifo.size() > 0) b = m_fifo.pop_front();
            if (g >= 0 && sp) begin
                m_acc   = g;
                b.data  = in_data[g*DW +: DW];
                b.sop   = in_sop[g];
                b.eop   = in_eop[g];
                b.empty = in_eop[g] ? in_empty[g*EW +: EW] : '0;
                b.ch    = g;
                b.cyc   = 0;
                if ((m_owner < 0 && !b.sop) || (m_owner >= 0 && b.sop)) m_perr = 1;
                m_fifo.push_back(b);
                if (b.eop) begin
                    m_owner = -1;
                    m_rr    = (g + 1) % NCH;
                end else begin
                    m_owner = g;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        int             g;
        logic [NCH-1:0] exp_rdy;
        logic           exp_perr;
        beat_t          lb;
        if (chk_en) begin
            g       = m_grant();
            exp_rdy = '0;
            if (g >= 0 && m_fifo.size() < 2) exp_rdy[g] = 1'b1;
`ifdef SHIM_AVST_PKT_MUX_PROTO_CHECK_EN
            exp_perr = m_perr;
`else
            exp_perr = 1'b0;
`endif
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) begin
                chk("out_data", out_data, m_fifo[0].data);
                chk("out_sop", 64'(out_sop), 64'(m_fifo[0].sop));
                chk("out_eop", 64'(out_eop), 64'(m_fifo[0].eop));
                chk("out_empty", 64'(out_empty), 64'(m_fifo[0].empty));
                chk("out_channel", 64'(out_channel), 64'(m_fifo[0].ch));
            end
            chk("proto_err", 64'(proto_err), 64'(exp_perr));
            if (in_ready[1] && s_idx[0] < s_len[0]) blk_flag = 1;
            if (out_valid && out_ready) begin
                lb.data  = out_data;
                lb.sop   = out_sop;
                lb.eop   = out_eop;
                lb.empty = out_empty;
                lb.ch    = int'(out_channel);
                lb.cyc   = cyc;
                log_q.push_back(lb);
            end
        end
    end

    task automatic drive();
        logic [NCH-1:0]    v, s, e;
        logic [NCH*DW-1:0] d;
        logic [NCH*EW-1:0] em;
        v = '0; s = '0; e = '0; d = '0; em = '0;
        for (int c = 0; c < NCH; c++) begin
            if (s_idx[c] < s_len[c]) begin
                v[c]            = 1'b1;
                s[c]            = s_sop[c][s_idx[c]];
                e[c]            = s_eop[c][s_idx[c]];
                d[c*DW +: DW]   = s_data[c][s_idx[c]];
                em[c*EW +: EW]  = s_empty[c][s_idx[c]];
            end
        end
        in_valid = v; in_sop = s; in_eop = e; in_data = d; in_empty = em;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (m_acc >= 0) s_idx[m_acc]++;
        drive();
    endtask

    task automatic clear_src();
        for (int c = 0; c < NCH; c++) begin
            s_len[c] = 0;
            s_idx[c] = 0;
        end
    endtask

    // Beat k of a packet: {channel, marker, packet id, k}; non-eop beats carry
    // a junk empty value that must not reach the output.
    task automatic add_beat(input int ch, input logic sop, input logic eop,
                            input logic [EW-1:0] emp, input int k);
        s_data[ch][s_len[ch]]  = {8'(ch), 24'h5A5A5A, 24'(pkt_id), 8'(k)};
        s_sop[ch][s_len[ch]]   = sop;
        s_eop[ch][s_len[ch]]   = eop;
        s_empty[ch][s_len[ch]] = eop ? emp : 3'd7;
        s_len[ch]++;
    endtask

    task automatic add_pkt(input int ch, input int n, input logic [EW-1:0] emp);
        for (int k = 0; k < n; k++) add_beat(ch, k == 0, k == n - 1, emp, k);
        pkt_id++;
    endtask

    function automatic bit all_idle();
        for (int c = 0; c < NCH; c++) if (s_idx[c] < s_len[c]) return 0;
        return m_fifo.size() == 0;
    endfunction

    task automatic drain(input string nm);
        int n = 0;
        while (!all_idle() && n < 200) begin
            tick();
            n++;
        end
        chk(nm, 64'(all_idle()), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_src();
        drive();
        tick();
        chk_en = 1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int start;
        reset     = 1'b1;
        out_ready = 1'b1;
        clear_src();
        drive();

        // Reset then idle
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_sop", 64'(out_sop), 64'd0);
        chk("rst_out_eop", 64'(out_eop), 64'd0);
        chk("rst_out_empty", 64'(out_empty), 64'd0);
        chk("rst_out_channel", 64'(out_channel), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        repeat (3) tick();

        // 3-beat packet on ch2
        log_q.delete();
        start = cyc;
        add_pkt(2, 3, 3'd5);
        drive();
        drain("t2_drain");
        chk("t2_nbeats", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("t2_cycle", 64'(log_q[k].cyc), 64'(start + 1 + k));
                chk("t2_chan", 64'(log_q[k].ch), 64'd2);
                chk("t2_beatno", 64'(log_q[k].data[7:0]), 64'(k));
            end
            chk("t2_sop0", 64'(log_q[0].sop), 64'd1);
            chk("t2_sop1", 64'(log_q[1].sop), 64'd0);
            chk("t2_eop1", 64'(log_q[1].eop), 64'd0);
            chk("t2_empty1", 64'(log_q[1].empty), 64'd0);
            chk("t2_eop2", 64'(log_q[2].eop), 64'd1);
            chk("t2_empty2", 64'(log_q[2].empty), 64'd5);
        end

        // ch0 and ch1 4-beat packets starting together, rr_ptr=0
        do_reset();
        log_q.delete();
        blk_flag = 0;
        add_pkt(0, 4, 3'd1);
        add_pkt(1, 4, 3'd2);
        drive();
        drain("t3_drain");
        chk("t3_nbeats", 64'(log_q.size()), 64'd8);
        chk("t3_ch1_blocked", 64'(blk_flag), 64'd0);
        if (log_q.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("t3_chan", 64'(log_q[k].ch), (k < 4) ? 64'd0 : 64'd1);
                chk("t3_beatno", 64'(log_q[k].data[7:0]), 64'(k % 4));
            end
        end

        // Single-beat packets on all channels: 0,1,2,3,0,1,2,3 with no bubbles
        do_reset();
        log_q.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NCH; c++) add_pkt(c, 1, 3'(c));
        drive();
        drain("t4_drain");
        chk("t4_nbeats", 64'(log_q.size()), 64'd8);
        if (log_q.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("t4_chan", 64'(log_q[k].ch), 64'(k % 4));
                chk("t4_nobubble", 64'(log_q[k].cyc - log_q[0].cyc), 64'(k));
                chk("t4_empty", 64'(log_q[k].empty), 64'(k % 4));
            end
        end

        // out_ready low for 5 cycles mid-packet
        log_q.delete();
        add_pkt(1, 8, 3'd2);
        drive();
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("t5_stall_rdy", 64'(in_ready), 64'd0);
        chk("t5_stall_vld", 64'(out_valid), 64'd1);
        tick();
        out_ready = 1'b1;
        drain("t5_drain");
        chk("t5_nbeats", 64'(log_q.size()), 64'd8);
        if (log_q.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("t5_order", 64'(log_q[k].data[7:0]), 64'(k));
                chk("t5_chan", 64'(log_q[k].ch), 64'd1);
            end
            chk("t5_empty7", 64'(log_q[7].empty), 64'd2);
        end

        // Reset during the second beat of a 4-beat packet, then ch3 packet
        do_reset();
        add_pkt(0, 4, 3'd1);
        drive();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_src();
        drive();
        @(negedge clk);
        chk("t6_rst_vld", 64'(out_valid), 64'd0);
        log_q.delete();
        add_pkt(3, 2, 3'd4);
        drive();
        drain("t6_drain");
        chk("t6_nbeats", 64'(log_q.size()), 64'd2);
        if (log_q.size() == 2) begin
            chk("t6_chan", 64'(log_q[0].ch), 64'd3);
            chk("t6_sop", 64'(log_q[0].sop), 64'd1);
            chk("t6_eop", 64'(log_q[1].eop), 64'd1);
            chk("t6_empty", 64'(log_q[1].empty), 64'd4);
        end

        // Beat with sop=0 while idle
        add_beat(3, 1'b0, 1'b1, 3'd0, 0);
        drive();
        drain("t7_drain");
`ifdef SHIM_AVST_PKT_MUX_PROTO_CHECK_EN
        chk("t7_proto_err", 64'(proto_err), 64'd1);
`else
        chk("t7_proto_err", 64'(proto_err), 64'd0);
`endif
        do_reset();
        chk("t7_proto_clr", 64'(proto_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
